// File: rtl/fifo_wr_arb.sv
// Round-robin two-requester write arbiter feeding a shared FIFO write port.
// Each grant carries a burst of up to BURST_LEN words; FIFO full stalls the owner without releasing it.
module fifo_wr_arb #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_full_flag,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [1:0]        grant,
  output logic              burst_done
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] beat_cnt_r;
  logic             last_owner_r;
  logic             burst_done_r;
  logic             accept_s;
  logic             release_s;
  logic             entry0_s;
  logic             entry1_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: IDLE arbitration favours the requester that did not own the last grant
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          state_nxt_s = last_owner_r ? GNT0 : GNT1;
        end else if (req0_valid) begin
          state_nxt_s = GNT0;
        end else if (req1_valid) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0: begin
        if (!req0_valid) begin
          state_nxt_s = IDLE;
        end else if (accept_s && (beat_cnt_r == LAST_BEAT)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT0;
        end
      end
      GNT1: begin
        if (!req1_valid) begin
          state_nxt_s = IDLE;
        end else if (accept_s && (beat_cnt_r == LAST_BEAT)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs: grant decode, owner ready gated by full, zero-latency write path
  always_comb begin
    grant        = 2'b00;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    accept_s     = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = {DATA_W{1'b0}};
    case (state_r)
      GNT0: begin
        grant      = 2'b01;
        req0_ready = ~fifo_full_flag;
        accept_s   = req0_valid & ~fifo_full_flag;
        if (accept_s) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = req0_data;
        end else begin
          fifo_wr_en   = 1'b0;
          fifo_wr_data = {DATA_W{1'b0}};
        end
      end
      GNT1: begin
        grant      = 2'b10;
        req1_ready = ~fifo_full_flag;
        accept_s   = req1_valid & ~fifo_full_flag;
        if (accept_s) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = req1_data;
        end else begin
          fifo_wr_en   = 1'b0;
          fifo_wr_data = {DATA_W{1'b0}};
        end
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  assign release_s = (state_r != IDLE) && (state_nxt_s == IDLE);
  assign entry0_s  = (state_r == IDLE) && (state_nxt_s == GNT0);
  assign entry1_s  = (state_r == IDLE) && (state_nxt_s == GNT1);

  // Burst bookkeeping: beat count, round-robin owner memory, release pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r   <= {CNT_W{1'b0}};
      last_owner_r <= 1'b1;
      burst_done_r <= 1'b0;
    end else begin
      if (state_r == IDLE) begin
        beat_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (entry0_s) begin
        last_owner_r <= 1'b0;
      end else if (entry1_s) begin
        last_owner_r <= 1'b1;
      end else begin
        last_owner_r <= last_owner_r;
      end
      burst_done_r <= release_s;
    end
  end

  assign burst_done = burst_done_r;

endmodule
